// File: rtl/store_buffer.sv
// Store buffer between the core and memory. It queues byte-masked stores and drains them to memory in order.
// Latency: a store pushed in cycle N is presented on mem_w* in cycle N+1 at the earliest.
// Backpressure: none is applied to the core; a push into a full buffer with no pop is dropped and sets sticky sb_overflow.
// Optional: define STBUF_FWD_EN to forward buffered store bytes onto load data (youngest match wins per byte lane).
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [3:0]  datamem_wr,
  input  logic [7:0]  data_out0,
  input  logic [7:0]  data_out1,
  input  logic [7:0]  data_out2,
  input  logic [7:0]  data_out3,
  output logic [31:0] data_in,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        sb_full,
  output logic        sb_empty,
  output logic        sb_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]   addr_q [DEPTH];
  logic [29:0]   addr_d [DEPTH];
  logic [3:0]    strb_q [DEPTH];
  logic [3:0]    strb_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic push_req, push, pop;

  assign sb_empty    = (count_q == '0);
  assign sb_full     = (count_q == CW'(DEPTH));
  assign sb_overflow = ovf_q;

  // A slot frees up in the same cycle as a pop, so a full buffer still accepts a push then.
  assign push_req = |datamem_wr;
  assign pop      = mem_wvalid && mem_wready;
  assign push     = push_req && (!sb_full || pop);

  // Head payload is gated to zero while empty so stale discarded entries never show.
  assign mem_wvalid = !sb_empty;
  assign mem_waddr  = sb_empty ? 32'd0 : {addr_q[rd_ptr_q], 2'b00};
  assign mem_wdata  = sb_empty ? 32'd0 : data_q[rd_ptr_q];
  assign mem_wstrb  = sb_empty ? 4'd0  : strb_q[rd_ptr_q];
  assign mem_raddr  = data_addr;

  // Next-state: write tail on push, advance head on pop, track occupancy and drops.
  always_comb begin
    addr_d   = addr_q;
    strb_d   = strb_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_req && sb_full && !pop);
    if (push) begin
      addr_d[wr_ptr_q] = data_addr[31:2];
      strb_d[wr_ptr_q] = datamem_wr;
      data_d[wr_ptr_q] = {data_out3, data_out2, data_out1, data_out0};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Control state with synchronous reset; reset overrides any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    strb_q <= strb_d;
    data_q <= data_d;
  end

`ifdef STBUF_FWD_EN
  logic [31:0]   fwd_data;
  logic [PW-1:0] fwd_idx;

  // Scan live entries oldest to youngest so the youngest matching byte overrides earlier ones.
  // Only registered entries are scanned, so a same-cycle push never forwards, and a popping head still does.
  always_comb begin
    fwd_data = mem_rdata;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == data_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (strb_q[fwd_idx][b]) begin
            fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign data_in = fwd_data;
`else
  assign data_in = mem_rdata;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected stores go into a queue, a monitor checks each memory handshake.
// Drives inputs 1 time unit after the rising edge, checks status mid-cycle, monitors handshakes on the falling edge.
// Forwarding expectations follow the STBUF_FWD_EN build macro.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_addr = '0;
  logic [3:0]  datamem_wr = '0;
  logic [7:0]  data_out0 = '0, data_out1 = '0, data_out2 = '0, data_out3 = '0;
  logic [31:0] data_in, mem_raddr;
  logic [31:0] mem_rdata = '0;
  logic        mem_wvalid;
  logic        mem_wready = 1'b0;
  logic [31:0] mem_waddr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        sb_full, sb_empty, sb_overflow;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .data_addr(data_addr), .datamem_wr(datamem_wr),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .data_in(data_in), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .sb_full(sb_full), .sb_empty(sb_empty), .sb_overflow(sb_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } st_t;

  st_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  hs_count = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a valid&ready seen mid-cycle completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && mem_wvalid && mem_wready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_store", {mem_waddr, mem_wdata, mem_wstrb}, 72'd0);
      end else begin
        st_t e;
        e = exp_q.pop_front();
        chk("drain_store", {mem_waddr, mem_wdata, mem_wstrb}, {e.addr, e.data, e.strb});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    data_addr  = a;
    datamem_wr = s;
    {data_out3, data_out2, data_out1, data_out0} = d;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input bit acc);
    drive_store(a, s, d);
    if (acc) exp_q.push_back('{addr: {a[31:2], 2'b00}, data: d, strb: s});
    cyc();
    datamem_wr = 4'd0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 20 && !sb_empty; i++) cyc();
    chk({name, "_empty"}, {71'd0, sb_empty}, 72'd1);
    chk({name, "_queue_left"}, 72'(exp_q.size()), 72'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    cyc();
    rst = 1'b0;
  endtask

  logic [31:0] fwd_exp, fwd_exp2;
  int hs_start;

  initial begin
`ifdef STBUF_FWD_EN
    fwd_exp  = 32'h1122BBCC;
    fwd_exp2 = 32'h1155BBCC;
`else
    fwd_exp  = 32'h11223344;
    fwd_exp2 = 32'h11223344;
`endif
    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_wvalid",   {71'd0, mem_wvalid},  72'd0);
    chk("rst_empty",    {71'd0, sb_empty},    72'd1);
    chk("rst_full",     {71'd0, sb_full},     72'd0);
    chk("rst_overflow", {71'd0, sb_overflow}, 72'd0);
    chk("rst_payload",  {mem_waddr, mem_wdata, mem_wstrb}, 72'd0);

    // Single store: accepted on first edge after reset, visible only next cycle
    rst        = 1'b0;
    mem_wready = 1'b1;
    drive_store(32'h100, 4'hF, 32'hDEADBEEF);
    exp_q.push_back('{addr: 32'h100, data: 32'hDEADBEEF, strb: 4'hF});
    #2;
    chk("s1_same_cycle_wvalid", {71'd0, mem_wvalid}, 72'd0);
    cyc();
    datamem_wr = 4'd0;
    chk("s1_next_wvalid", {71'd0, mem_wvalid}, 72'd1);
    chk("s1_next_head", {mem_waddr, mem_wdata}, {40'd0, 32'h100, 32'hDEADBEEF} & 72'hFF_FFFFFFFF_FFFFFFFF);
    cyc();
    chk("s1_empty_after", {71'd0, sb_empty}, 72'd1);
    chk("s1_queue_left", 72'(exp_q.size()), 72'd0);

    // Overflow: 5 pushes into a stalled 4-deep buffer
    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4 * i), 4'hF, 32'hA0A0_0000 + 32'(i), 1'b1);
    chk("s2_full", {71'd0, sb_full}, 72'd1);
    chk("s2_no_overflow_yet", {71'd0, sb_overflow}, 72'd0);
    push(32'h1010, 4'hF, 32'hBAD0BAD0, 1'b0);
    chk("s2_overflow", {71'd0, sb_overflow}, 72'd1);
    chk("s2_still_full", {71'd0, sb_full}, 72'd1);
    chk("s2_head_stable", {mem_waddr, mem_wdata}, {40'd0, 32'h1000, 32'hA0A0_0000} & 72'hFF_FFFFFFFF_FFFFFFFF);
    mem_wready = 1'b1;
    wait_empty("s2");
    chk("s2_overflow_sticky", {71'd0, sb_overflow}, 72'd1);
    do_reset();
    chk("s2_overflow_cleared", {71'd0, sb_overflow}, 72'd0);

    // Full with simultaneous push and pop
    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'(4 * i), 4'hF, 32'hC0C0_0000 + 32'(i), 1'b1);
    chk("s3_full", {71'd0, sb_full}, 72'd1);
    mem_wready = 1'b1;
    push(32'h200, 4'hF, 32'h0000_0200, 1'b1);
    chk("s3_full_kept", {71'd0, sb_full}, 72'd1);
    chk("s3_no_overflow", {71'd0, sb_overflow}, 72'd0);
    wait_empty("s3");
    chk("s3_overflow_final", {71'd0, sb_overflow}, 72'd0);

    // Forwarding of buffered bytes onto load data
    mem_wready = 1'b0;
    push(32'h40, 4'h1, 32'h0000_00AA, 1'b1);
    push(32'h40, 4'h3, 32'h0000_BBCC, 1'b1);
    data_addr = 32'h40;
    mem_rdata = 32'h11223344;
    #2;
    chk("s4_raddr", 72'(mem_raddr), 72'h40);
    chk("s4_load_fwd", 72'(data_in), 72'(fwd_exp));
    data_addr = 32'h44;
    #1;
    chk("s4_load_nomatch", 72'(data_in), 72'h11223344);
    // a same-cycle push must not forward
    drive_store(32'h40, 4'h4, 32'h0055_0000);
    exp_q.push_back('{addr: 32'h40, data: 32'h0055_0000, strb: 4'h4});
    #1;
    chk("s4_same_cycle_push", 72'(data_in), 72'(fwd_exp));
    cyc();
    datamem_wr = 4'd0;
    chk("s4_load_after_push", 72'(data_in), 72'(fwd_exp2));

    // Reset while stalled with 3 entries, plus a concurrent push
    chk("s5_wvalid_before", {71'd0, mem_wvalid}, 72'd1);
    rst = 1'b1;
    exp_q.delete();
    drive_store(32'h500, 4'hF, 32'h5555_5555);
    cyc();
    datamem_wr = 4'd0;
    rst = 1'b0;
    chk("s5_wvalid", {71'd0, mem_wvalid}, 72'd0);
    chk("s5_empty", {71'd0, sb_empty}, 72'd1);
    chk("s5_overflow", {71'd0, sb_overflow}, 72'd0);
    chk("s5_payload", {mem_waddr, mem_wdata, mem_wstrb}, 72'd0);

    // Continuous pushes with ready high: pointers wrap twice, nothing lost
    mem_wready = 1'b1;
    hs_start = hs_count;
    for (int i = 0; i < 2 * DEPTH; i++) push(32'h300, 4'hF, 32'h3000_0000 + 32'(i), 1'b1);
    wait_empty("s6");
    chk("s6_handshakes", 72'(hs_count - hs_start), 72'(2 * DEPTH));

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` and `rst`.
REQ-002 Parameter: DEPTH, default 4, number of buffered stores; it SHALL be a power of two, 2..16.
REQ-003 clk  in  1  core/system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 data_addr  in  32  core load/store byte address.
REQ-006 datamem_wr  in  4  core store byte enables; bit i qualifies data_outi; 0 = no store.
REQ-007 data_out0..data_out3  in  8 each  core store bytes, lane 0 = bits 7:0.
REQ-008 data_in  out  32  load data returned to core.
REQ-009 mem_raddr  out  32  memory read address.
REQ-010 mem_rdata  in  32  memory read data, combinational from mem_raddr.
REQ-011 mem_wvalid  out  1  head store valid.
REQ-012 mem_wready  in  1  memory accepts head store.
REQ-013 mem_waddr  out  32  head store word address, bits 1:0 = 0.
REQ-014 mem_wdata  out  32  head store data.
REQ-015 mem_wstrb  out  4  head store byte strobes.
REQ-016 sb_full, sb_empty, sb_overflow  out  1 each  occupancy==DEPTH, occupancy==0, sticky drop flag.

Function
REQ-017 Push: when datamem_wr != 0 and a slot is free, the buffer SHALL store {data_addr[31:2], datamem_wr, data_out3..0} at the tail.
  - Entry becomes visible to drain and forwarding the next cycle.
REQ-018 Drain: mem_wvalid SHALL equal !sb_empty; mem_waddr/wdata/wstrb SHALL show the oldest entry.
  - The entry is popped on a cycle with mem_wvalid && mem_wready.
  - The payload SHALL stay stable while valid and not ready.
REQ-019 Order: stores SHALL reach memory strictly in push order, one per accepted handshake, at most one per cycle.
REQ-020 Occupancy counter, 0..DEPTH:
  - +1 on push only; -1 on pop only; unchanged on push+pop.
  - Read and write pointers SHALL wrap modulo DEPTH.
REQ-021 Full with push and pop in the same cycle: the push SHALL be accepted, occupancy stays DEPTH.
REQ-022 Full with push and no pop: the store SHALL be dropped, contents unchanged, and sb_overflow set until reset.
REQ-023 Empty: mem_wvalid=0. A push while empty SHALL give mem_wvalid=1 on the next cycle, never the same cycle.
REQ-024 mem_raddr SHALL equal data_addr combinationally. Without forwarding, data_in SHALL equal mem_rdata combinationally.
REQ-025 Loads and stores from the core SHALL never be stalled; the block has no backpressure to the core.

Reset
REQ-026 When rst=1 at a clock edge:
  - Pointers, occupancy and sb_overflow SHALL clear to 0; contents are discarded.
  - Outputs SHALL be mem_wvalid=0, sb_empty=1, sb_full=0; mem_waddr/wdata/wstrb = 0.
REQ-027 Reset SHALL win over push and pop in the same cycle, including an in-progress mem_wvalid-without-ready.
REQ-028 The first push SHALL be accepted on the first edge with rst=0.

Configuration
REQ-029 Macro STBUF_FWD_EN.
  - When defined: for each byte lane, data_in SHALL take the byte from the youngest valid entry whose word address equals data_addr[31:2] and whose strobe for that lane is set; lanes with no match take mem_rdata.
  - When not defined: REQ-024 applies, with no comparators.
REQ-030 Forwarding SHALL cover only entries pushed in earlier cycles, never the same-cycle push. An entry popped this cycle is still a match source this cycle.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
  - Reset, then push addr 0x100 strb 0xF data 0xDEADBEEF with mem_wready=1 -> next cycle mem_wvalid=1, waddr 0x100, wdata 0xDEADBEEF; empty the cycle after.
  - mem_wready=0, push 5 stores (DEPTH=4) -> sb_full=1 after 4th; 5th dropped, sb_overflow=1; with ready=1, exactly the first 4 drain in order.
  - Full and mem_wready=1 with a simultaneous push of 0x200 -> occupancy stays 4; 0x200 drains last; sb_overflow stays 0.
  - STBUF_FWD_EN, wready=0:
    - push 0x40 strb 0x1 data 0x000000AA, then push 0x40 strb 0x3 data 0x0000BBCC;
    - load 0x40 with mem_rdata 0x11223344 -> data_in 0x1122BBCC;
    - without the macro -> 0x11223344.
  - rst asserted while mem_wvalid=1, wready=0, occupancy 3 -> next cycle mem_wvalid=0, sb_empty=1, sb_overflow=0.
  - Push 0x300 every cycle for 2*DEPTH cycles with mem_wready=1 -> pointer wrap with no loss; 2*DEPTH handshakes observed.
